// File: rtl/masked_share_encoder.sv
// masked_share_encoder: front end of the 2-share masked datapath.
// Takes a plaintext word, gathers WIDTH+NREF fresh random bits one per RNG
// handshake, then presents Boolean shares (share0 ^ share1 = plaintext)
// together with NREF refresh bits for the downstream masked gates.
// Plaintext and random material are wiped as soon as the shares are formed,
// and the shares are wiped once the consumer has taken them.
module masked_share_encoder #(
  parameter int WIDTH = 3,
  parameter int NREF  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             rnd_valid,
  input  logic             rnd_bit,
  output logic             rnd_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_share0,
  output logic [WIDTH-1:0] out_share1,
  output logic [NREF-1:0]  out_rn,
  input  logic             out_ready
);

  localparam int NRND = WIDTH + NREF;
  localparam int CW   = $clog2(NRND + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NRND - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pt;
  logic [NRND-1:0]  r_rnd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_share0;
  logic [WIDTH-1:0] r_share1;
  logic [NREF-1:0]  r_rn;

  // Random register with the incoming bit merged in at the current index,
  // so the final bit can feed the share computation on the same edge.
  logic [NRND-1:0]  w_rnd_next;

  // Merge the offered random bit into its slot.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    w_rnd_next        = r_rnd;
    w_rnd_next[r_cnt] = rnd_bit;
  end

  // Encoder FSM with all datapath registers; clear and reset zeroize everything.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the random and plaintext registers are reset too: they hold secrets
    // and must never survive a reset with stale contents.
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pt     <= '0;
      r_rnd    <= '0;
      r_cnt    <= '0;
      r_share0 <= '0;
      r_share1 <= '0;
      r_rn     <= '0;
    end else if (clear) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      r_state  <= S_IDLE;
      r_pt     <= '0;
      r_rnd    <= '0;
      r_cnt    <= '0;
      r_share0 <= '0;
      r_share1 <= '0;
      r_rn     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_pt    <= in_data;
            r_rnd   <= '0;
            r_cnt   <= '0;
            r_state <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (rnd_valid) begin
            if (r_cnt == LAST_IDX) begin
              // Shares are formed directly from the registered plaintext and
              // the completed mask; the sources are wiped on the same edge.
              r_share0 <= r_pt ^ w_rnd_next[WIDTH-1:0];
              r_share1 <= w_rnd_next[WIDTH-1:0];
              r_rn     <= w_rnd_next[NRND-1:WIDTH];
              r_pt     <= '0;
              r_rnd    <= '0;
              r_cnt    <= '0;
              r_state  <= S_OUT;
            end else begin
              r_rnd <= w_rnd_next;
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        S_OUT: begin
          if (out_ready) begin
            r_share0 <= '0;
            r_share1 <= '0;
            r_rn     <= '0;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake flags are pure decodes of the registered state.
  assign in_ready   = (r_state == S_IDLE);
  assign rnd_ready  = (r_state == S_COLLECT);
  assign out_valid  = (r_state == S_OUT);
  assign out_share0 = r_share0;
  assign out_share1 = r_share1;
  assign out_rn     = r_rn;

endmodule

// File: tb/tb_masked_share_encoder.sv
// Testbench for masked_share_encoder: directed scenarios with hand-computed
// literals plus a transaction-level model compared against the DUT every cycle.
module tb_masked_share_encoder;

  localparam int W  = 3;
  localparam int NR = 2;
  localparam int NB = W + NR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          rnd_valid;
  logic          rnd_bit;
  logic          rnd_ready;
  logic          out_valid;
  logic [W-1:0]  out_share0;
  logic [W-1:0]  out_share1;
  logic [NR-1:0] out_rn;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  masked_share_encoder #(.WIDTH(W), .NREF(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rnd_valid  (rnd_valid),
    .rnd_bit    (rnd_bit),
    .rnd_ready  (rnd_ready),
    .out_valid  (out_valid),
    .out_share0 (out_share0),
    .out_share1 (out_share1),
    .out_rn     (out_rn),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level model: a word is either absent, gathering bits, or
  // waiting to be delivered. Expected outputs follow from that alone.
  // ---------------------------------------------------------------------
  logic          m_have_pt  = 1'b0;
  logic [W-1:0]  m_pt       = '0;
  logic          m_bits[$];
  logic          m_pending  = 1'b0;
  logic [W-1:0]  m_s0       = '0;
  logic [W-1:0]  m_s1       = '0;
  logic [NR-1:0] m_rn       = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_have_pt = 1'b0;
      m_pt      = '0;
      m_bits.delete();
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (out_ready) m_pending = 1'b0;
    end else if (m_have_pt) begin
      if (rnd_valid) begin
        m_bits.push_back(rnd_bit);
        if (m_bits.size() == NB) begin
          for (int i = 0; i < W; i++)  m_s1[i] = m_bits[i];
          for (int i = 0; i < NR; i++) m_rn[i] = m_bits[W+i];
          m_s0      = m_pt ^ m_s1;
          m_pending = 1'b1;
          m_have_pt = 1'b0;
          m_bits.delete();
        end
      end
    end else if (in_valid) begin
      m_have_pt = 1'b1;
      m_pt      = in_data;
      m_bits.delete();
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    check("in_ready",   int'(in_ready),   int'(!m_have_pt && !m_pending));
    check("rnd_ready",  int'(rnd_ready),  int'(m_have_pt));
    check("out_valid",  int'(out_valid),  int'(m_pending));
    check("out_share0", int'(out_share0), m_pending ? int'(m_s0) : 0);
    check("out_share1", int'(out_share1), m_pending ? int'(m_s1) : 0);
    check("out_rn",     int'(out_rn),     m_pending ? int'(m_rn) : 0);
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] pt, output int start);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    in_valid = 1'b1;
    in_data  = pt;
    start    = cyc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rnd_valid = 1'b1;
    rnd_bit   = b;
    step();
    rnd_valid = 1'b0;
    rnd_bit   = 1'b0;
  endtask

  task automatic send_bits(input logic [NB-1:0] bits);
    for (int i = 0; i < NB; i++) send_bit(bits[i]);
  endtask

  task automatic wait_out(input int start, input int exp_lat, input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check({name, "_latency"}, cyc - start, exp_lat);
  endtask

  task automatic check_outs(input string name, input logic [W-1:0] s0,
                            input logic [W-1:0] s1, input logic [NR-1:0] rn);
    check({name, "_valid"},  int'(out_valid),  1);
    check({name, "_share0"}, int'(out_share0), int'(s0));
    check({name, "_share1"}, int'(out_share1), int'(s1));
    check({name, "_rn"},     int'(out_rn),     int'(rn));
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"},  int'(out_valid),  0);
    check({name, "_share0"}, int'(out_share0), 0);
    check({name, "_share1"}, int'(out_share1), 0);
    check({name, "_rn"},     int'(out_rn),     0);
    check({name, "_in_rdy"}, int'(in_ready),   1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic [W-1:0] pt;
    logic [W-1:0] mask;
    logic [NR-1:0] rn;
    logic q[$];

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    rnd_valid = 1'b0; rnd_bit = 1'b0; out_ready = 1'b0;
    #3;
    check("reset_in_ready",  int'(in_ready),  1);
    check("reset_rnd_ready", int'(rnd_ready), 0);
    check_zero("reset");
    #19 rst_n = 1'b1;
    step();

    // Basic encode: 101 with bits 1,1,0,1,0 (bit k lands at index k).
    out_ready = 1'b1;
    send_word(3'b101, s);
    send_bits(5'b01011);
    wait_out(s, 6, "basic");
    check_outs("basic", 3'b110, 3'b011, 2'b01);
    step();
    check_zero("basic_after");

    // RNG stall of 3 cycles between the third and fourth bit.
    send_word(3'b101, s);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 3; i++) begin
      check("stall_rnd_ready", int'(rnd_ready), 1);
      step();
    end
    send_bit(1'b1); send_bit(1'b0);
    wait_out(s, 9, "stall");
    check_outs("stall", 3'b110, 3'b011, 2'b01);
    step();
    check_zero("stall_after");

    // RNG offers bits while idle: none may be consumed.
    out_ready = 1'b0;
    rnd_valid = 1'b1; rnd_bit = 1'b1;
    step(); step();
    check("idle_rnd_ready", int'(rnd_ready), 0);
    rnd_valid = 1'b0; rnd_bit = 1'b0;

    // Backpressure, with in_valid held during COLLECT/OUT and rnd_valid in OUT.
    send_word(3'b100, s);
    in_valid = 1'b1; in_data = 3'b001;
    send_bits(5'b10110);
    wait_out(s, 6, "bp");
    rnd_valid = 1'b1; rnd_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_outs("bp_hold", 3'b010, 3'b110, 2'b10);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_rnd_ready", int'(rnd_ready), 0);
      step();
    end
    in_valid = 1'b0; rnd_valid = 1'b0; rnd_bit = 1'b0;
    out_ready = 1'b1;
    step();
    check_zero("bp_after");
    send_word(3'b010, s);
    send_bits(5'b00000);
    wait_out(s, 6, "second");
    check_outs("second", 3'b010, 3'b000, 2'b00);
    step();

    // Clear after two random bits.
    send_word(3'b101, s);
    send_bit(1'b1); send_bit(1'b1);
    clear = 1'b1; rnd_valid = 1'b1; rnd_bit = 1'b1;
    step();
    clear = 1'b0; rnd_valid = 1'b0; rnd_bit = 1'b0;
    check("clear_rnd_ready", int'(rnd_ready), 0);
    check_zero("clear");
    // Clear in IDLE beats a plaintext offer.
    clear = 1'b1; in_valid = 1'b1; in_data = 3'b111;
    step();
    clear = 1'b0; in_valid = 1'b0;
    check("clear_idle_in_ready", int'(in_ready), 1);
    send_word(3'b111, s);
    send_bits(5'b11110);
    wait_out(s, 6, "post_clear");
    check_outs("post_clear", 3'b001, 3'b110, 2'b11);
    step();

    // Asynchronous reset pulse between edges while shares are presented.
    out_ready = 1'b0;
    send_word(3'b011, s);
    send_bits(5'b01101);
    wait_out(s, 6, "pre_reset");
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    #1 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send_word(3'b011, s);
    send_bits(5'b01101);
    wait_out(s, 6, "post_reset");
    check_outs("post_reset", 3'b110, 3'b101, 2'b01);
    step();

    // Randomized words with random RNG gaps and output backpressure.
    out_ready = 1'b0;
    for (int w = 0; w < 1000; w++) begin
      int n;
      logic hs;
      pt = W'($urandom_range(0, (1 << W) - 1));
      send_word(pt, s);
      q.delete();
      n = 0;
      while (!out_valid && n < 200) begin
        rnd_valid = ($urandom_range(0, 3) != 0);
        rnd_bit   = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = W'($urandom_range(0, (1 << W) - 1));
        if (rnd_valid && rnd_ready) q.push_back(rnd_bit);
        step();
        n++;
      end
      rnd_valid = 1'b0; in_valid = 1'b0;
      check("rand_bits_used", q.size(), NB);
      mask = '0; rn = '0;
      if (q.size() == NB) begin
        for (int i = 0; i < W; i++)  mask[i] = q[i];
        for (int i = 0; i < NR; i++) rn[i]   = q[W+i];
      end
      check("rand_recombine", int'(out_share0 ^ out_share1), int'(pt));
      check("rand_share1",    int'(out_share1), int'(mask));
      check("rand_rn",        int'(out_rn),     int'(rn));
      n = 0;
      hs = 1'b0;
      while (!hs && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        hs = out_ready && out_valid;
        step();
        n++;
      end
      out_ready = 1'b0;
      check("rand_handshake", int'(hs), 1);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
